// File: rtl/ahb_bm_pkg.sv
// ahb_bm_pkg: shared AHB encodings and state types for the bus-matrix slice.
//   HTRANS, HBURST and HRESP encodings plus the input-stage state type used
//   when the hold-timeout feature (AHB_BM_IN_TIMEOUT_EN) is compiled in.
package ahb_bm_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } in_state_e;

endpackage

// File: rtl/ahb_bm_hold_timer.sv
// ahb_bm_hold_timer: counts consecutive cycles a held transfer waits for a
// grant and flags expiry on the cycle the count would reach TIMEOUT_CYCLES.
// Only instantiated when AHB_BM_IN_TIMEOUT_EN is defined.
// Ports:
//   HCLK   clock
//   HRESET synchronous active-high reset
//   run    hold pending and not issued this cycle
//   expire pulse: this is the TIMEOUT_CYCLES-th waiting cycle
module ahb_bm_hold_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic run,
  output logic expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt;

  always_ff @(posedge HCLK) begin
    if (HRESET)   cnt <= '0;
    else if (run) cnt <= cnt + 16'd1;
    else          cnt <= '0;
  end

  // Count starts at 0 on the first waiting cycle, so LIMIT marks the last one.
  assign expire = run & (cnt == LIMIT);

endmodule

// File: rtl/ahb_bm_input_stage.sv
// ahb_bm_input_stage: per-master input stage of the AHB bus matrix.
//   Holds a master address phase that cannot be issued at once, stalls the
//   master while it is held, presents live or held phase to decode/arbitration
//   and routes data-phase ready/response back.
// Optional: AHB_BM_IN_TIMEOUT_EN adds a hold timeout that drops the held
//   transfer after TIMEOUT_CYCLES and answers the master with a 2-cycle ERROR.
// Ports:
//   HCLK, HRESET                 clock, synchronous active-high reset
//   HSELS..HMASTLOCKS, HREADYS   master address phase and bus ready
//   active_ph, readyout_ph       grant from output port, owning slave ready
//   resp_ph                      data-phase slave response
//   HREADYOUTS, HRESPS           ready/response to master
//   *_ph, req_ph                 selected address phase and arbiter request
//   held_tran                    a buffered transfer is pending
module ahb_bm_input_stage
  import ahb_bm_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  input  logic              active_ph,
  input  logic              readyout_ph,
  input  logic [1:0]        resp_ph,
  output logic              HREADYOUTS,
  output logic [1:0]        HRESPS,
  output logic              sel_ph,
  output logic [ADDR_W-1:0] addr_ph,
  output logic [1:0]        trans_ph,
  output logic              write_ph,
  output logic [2:0]        size_ph,
  output logic [2:0]        burst_ph,
  output logic [3:0]        prot_ph,
  output logic              mastlock_ph,
  output logic              req_ph,
  output logic              held_tran
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_chk
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  logic              live_xfer, issue, load;
  logic              err_wait, err_last;
  logic              dphase;
  logic              hold_sel, hold_write, hold_lock;
  logic [ADDR_W-1:0] hold_addr;
  logic [1:0]        hold_trans;
  logic [2:0]        hold_size, hold_burst;
  logic [3:0]        hold_prot;

  assign live_xfer = HSELS & HREADYS & HTRANSS[1];
  assign issue     = active_ph & readyout_ph;
  // The master is stalled during ERR1, so nothing may be captured then.
  assign load      = live_xfer & ~held_tran & ~issue & ~err_wait;

`ifdef AHB_BM_IN_TIMEOUT_EN
  in_state_e state;
  logic      hold_run, expire;

  assign hold_run = held_tran & ~issue;

  ahb_bm_hold_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_hold_timer (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .run    (hold_run),
    .expire (expire)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (load) state <= ST_HOLD;
        ST_HOLD: begin
          if (issue)       state <= ST_IDLE;
          else if (expire) state <= ST_ERR1;
        end
        ST_ERR1: state <= ST_ERR2;
        // Master may start a new transfer in the last error cycle.
        ST_ERR2: state <= load ? ST_HOLD : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign held_tran = (state == ST_HOLD);
  assign err_wait  = (state == ST_ERR1);
  assign err_last  = (state == ST_ERR2);
`else
  always_ff @(posedge HCLK) begin
    if (HRESET)                 held_tran <= 1'b0;
    else if (held_tran & issue) held_tran <= 1'b0;
    else if (load)              held_tran <= 1'b1;
  end

  assign err_wait = 1'b0;
  assign err_last = 1'b0;
`endif

  // Hold register: captures the full master address phase on load.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hold_sel   <= 1'b0;
      hold_addr  <= '0;
      hold_trans <= HTRANS_IDLE;
      hold_write <= 1'b0;
      hold_size  <= '0;
      hold_burst <= HBURST_SINGLE;
      hold_prot  <= '0;
      hold_lock  <= 1'b0;
    end else if (load) begin
      hold_sel   <= HSELS;
      hold_addr  <= HADDRS;
      hold_trans <= HTRANSS;
      hold_write <= HWRITES;
      hold_size  <= HSIZES;
      hold_burst <= HBURSTS;
      hold_prot  <= HPROTS;
      hold_lock  <= HMASTLOCKS;
    end
  end

  always_comb begin
    sel_ph      = HSELS;
    addr_ph     = HADDRS;
    trans_ph    = HTRANSS;
    write_ph    = HWRITES;
    size_ph     = HSIZES;
    burst_ph    = HBURSTS;
    prot_ph     = HPROTS;
    mastlock_ph = HMASTLOCKS;
    if (held_tran) begin
      sel_ph      = hold_sel;
      addr_ph     = hold_addr;
      trans_ph    = hold_trans;
      write_ph    = hold_write;
      size_ph     = hold_size;
      burst_ph    = hold_burst;
      prot_ph     = hold_prot;
      mastlock_ph = hold_lock;
    end
  end

  assign req_ph = sel_ph & trans_ph[1];

  // Data-phase tracker: set by an issued NONSEQ/SEQ, cleared when it completes.
  always_ff @(posedge HCLK) begin
    if (HRESET)           dphase <= 1'b0;
    else if (issue)       dphase <= trans_ph[1];
    else if (readyout_ph) dphase <= 1'b0;
  end

  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = dphase ? resp_ph : HRESP_OKAY;
    if (err_wait) begin
      HREADYOUTS = 1'b0;
      HRESPS     = HRESP_ERROR;
    end else if (err_last) begin
      HREADYOUTS = 1'b1;
      HRESPS     = HRESP_ERROR;
    end else if (held_tran) begin
      HREADYOUTS = 1'b0;
    end else if (dphase) begin
      HREADYOUTS = readyout_ph;
    end
  end

endmodule

// File: tb/tb_ahb_bm_input_stage.sv
// tb_ahb_bm_input_stage: directed self-checking bench for ahb_bm_input_stage.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units
// later, well before the next edge. Timeout checks apply when the design is
// built with AHB_BM_IN_TIMEOUT_EN (TIMEOUT_CYCLES=4 here).
module tb_ahb_bm_input_stage;
  import ahb_bm_pkg::*;

  logic        HCLK, HRESET;
  logic        HSELS, HWRITES, HMASTLOCKS, HREADYS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic [2:0]  HSIZES, HBURSTS;
  logic [3:0]  HPROTS;
  logic        active_ph, readyout_ph;
  logic [1:0]  resp_ph;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;
  logic        sel_ph, write_ph, mastlock_ph, req_ph, held_tran;
  logic [31:0] addr_ph;
  logic [1:0]  trans_ph;
  logic [2:0]  size_ph, burst_ph;
  logic [3:0]  prot_ph;

  int n_assert = 0;
  int n_fail   = 0;

  ahb_bm_input_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .active_ph(active_ph), .readyout_ph(readyout_ph), .resp_ph(resp_ph),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .sel_ph(sel_ph),
    .addr_ph(addr_ph), .trans_ph(trans_ph), .write_ph(write_ph),
    .size_ph(size_ph), .burst_ph(burst_ph), .prot_ph(prot_ph),
    .mastlock_ph(mastlock_ph), .req_ph(req_ph), .held_tran(held_tran)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                       input logic wr, input logic hrdy, input logic act,
                       input logic rdy, input logic [1:0] resp);
    HSELS = sel; HTRANSS = trans; HADDRS = addr; HWRITES = wr;
    HREADYS = hrdy; active_ph = act; readyout_ph = rdy; resp_ph = resp;
  endtask

  initial begin
    HRESET = 1'b1;
    HSIZES = 3'd0; HBURSTS = HBURST_SINGLE; HPROTS = 4'd0; HMASTLOCKS = 1'b0;
    drive(0, HTRANS_IDLE, 32'h0, 0, 1, 0, 1, HRESP_OKAY);
    tick(); tick();
    HRESET = 1'b0;
    #2;
    chk("rst_held", held_tran, 0);
    chk("rst_ready", HREADYOUTS, 1);
    chk("rst_resp", HRESPS, HRESP_OKAY);
    chk("rst_req", req_ph, 0);

    // Pass-through: granted in the same cycle, no hold
    tick(); drive(1, HTRANS_NONSEQ, 32'h4000_0000, 0, 1, 1, 1, HRESP_OKAY); #2;
    chk("pt_addr", addr_ph, 32'h4000_0000);
    chk("pt_req", req_ph, 1);
    chk("pt_held0", held_tran, 0);
    tick(); drive(0, HTRANS_IDLE, 32'h0, 0, 1, 0, 1, HRESP_OKAY); #2;
    chk("pt_held1", held_tran, 0);
    chk("pt_ready", HREADYOUTS, 1);

    // Hold: three cycles held, granted on the third
    tick(); drive(1, HTRANS_NONSEQ, 32'h2000_0010, 0, 1, 0, 1, HRESP_OKAY);
    HSIZES = 3'b010; HBURSTS = HBURST_INCR4; HPROTS = 4'b0011; HMASTLOCKS = 1'b1; #2;
    chk("hd_live_addr", addr_ph, 32'h2000_0010);
    chk("hd_live_req", req_ph, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(0, HTRANS_IDLE, 32'hDEAD_BEEF, 1, 0, (i == 2), 1, HRESP_OKAY);
      HSIZES = 3'd0; HBURSTS = HBURST_SINGLE; HPROTS = 4'd0; HMASTLOCKS = 1'b0; #2;
      chk("hd_held", held_tran, 1);
      chk("hd_ready", HREADYOUTS, 0);
      chk("hd_addr", addr_ph, 32'h2000_0010);
      chk("hd_req", req_ph, 1);
      chk("hd_write", write_ph, 0);
      chk("hd_size", size_ph, 3'b010);
      chk("hd_burst", burst_ph, HBURST_INCR4);
      chk("hd_prot", prot_ph, 4'b0011);
      chk("hd_lock", mastlock_ph, 1);
    end
    // After the grant edge the held transfer is in its data phase
    tick(); drive(0, HTRANS_IDLE, 32'h0, 0, 1, 0, 0, HRESP_OKAY); #2;
    chk("hd_clr_held", held_tran, 0);
    chk("hd_clr_req", req_ph, 0);
    chk("hd_dph_wait", HREADYOUTS, 0);
    tick(); readyout_ph = 1'b1; #2;
    chk("hd_dph_done", HREADYOUTS, 1);

    // Data-phase wait: issued write, slave waits two cycles
    tick(); drive(1, HTRANS_NONSEQ, 32'h3000_0004, 1, 1, 1, 1, HRESP_OKAY); #2;
    chk("dw_write", write_ph, 1);
    chk("dw_held", held_tran, 0);
    tick(); drive(0, HTRANS_IDLE, 32'h0, 0, 1, 0, 0, HRESP_OKAY); #2;
    chk("dw_rdy0a", HREADYOUTS, 0);
    tick(); #2;
    chk("dw_rdy0b", HREADYOUTS, 0);
    tick(); readyout_ph = 1'b1; #2;
    chk("dw_rdy1", HREADYOUTS, 1);

    // Error passthrough: two-cycle ERROR from the slave
    tick(); drive(1, HTRANS_NONSEQ, 32'h5000_0000, 0, 1, 1, 1, HRESP_OKAY); #2;
    chk("er_pre_resp", HRESPS, HRESP_OKAY);
    tick(); drive(0, HTRANS_IDLE, 32'h0, 0, 1, 0, 0, HRESP_ERROR); #2;
    chk("er_c1_resp", HRESPS, HRESP_ERROR);
    chk("er_c1_ready", HREADYOUTS, 0);
    tick(); readyout_ph = 1'b1; #2;
    chk("er_c2_resp", HRESPS, HRESP_ERROR);
    chk("er_c2_ready", HREADYOUTS, 1);
    tick(); #2;
    chk("er_gated_resp", HRESPS, HRESP_OKAY);
    chk("er_idle_ready", HREADYOUTS, 1);

    // No hold for BUSY, unselected, or HREADYS low
    tick(); drive(1, HTRANS_BUSY, 32'h6000_0000, 0, 1, 0, 1, HRESP_OKAY); #2;
    chk("nx_busy_req", req_ph, 0);
    tick(); drive(0, HTRANS_NONSEQ, 32'h6000_0000, 0, 1, 0, 1, HRESP_OKAY); #2;
    chk("nx_busy_held", held_tran, 0);
    chk("nx_nosel_req", req_ph, 0);
    tick(); drive(1, HTRANS_NONSEQ, 32'h6000_0000, 0, 0, 0, 1, HRESP_OKAY); #2;
    chk("nx_nosel_held", held_tran, 0);
    tick(); drive(0, HTRANS_IDLE, 32'h0, 0, 1, 0, 1, HRESP_OKAY); #2;
    chk("nx_nrdy_held", held_tran, 0);

    // Reset mid-hold discards the held transfer
    tick(); drive(1, HTRANS_NONSEQ, 32'h7000_0000, 0, 1, 0, 1, HRESP_OKAY);
    tick(); drive(0, HTRANS_IDLE, 32'h0, 0, 0, 0, 1, HRESP_OKAY); #2;
    chk("rh_held_pre", held_tran, 1);
    HRESET = 1'b1;
    tick(); HRESET = 1'b0; #2;
    chk("rh_held", held_tran, 0);
    chk("rh_req", req_ph, 0);
    chk("rh_ready", HREADYOUTS, 1);
    chk("rh_addr", addr_ph, 32'h0);

`ifdef AHB_BM_IN_TIMEOUT_EN
    // Timeout: four waiting cycles, then ERR1 and ERR2
    tick(); drive(1, HTRANS_NONSEQ, 32'h8000_0000, 0, 1, 0, 1, HRESP_OKAY);
    for (int i = 0; i < 4; i++) begin
      tick(); drive(0, HTRANS_IDLE, 32'h0, 0, 0, 0, 1, HRESP_OKAY); #2;
      chk("to_held", held_tran, 1);
      chk("to_ready", HREADYOUTS, 0);
      chk("to_resp", HRESPS, HRESP_OKAY);
    end
    tick(); #2;
    chk("to_e1_held", held_tran, 0);
    chk("to_e1_req", req_ph, 0);
    chk("to_e1_ready", HREADYOUTS, 0);
    chk("to_e1_resp", HRESPS, HRESP_ERROR);
    tick(); HREADYS = 1'b1; #2;
    chk("to_e2_ready", HREADYOUTS, 1);
    chk("to_e2_resp", HRESPS, HRESP_ERROR);
    tick(); #2;
    chk("to_end_ready", HREADYOUTS, 1);
    chk("to_end_resp", HRESPS, HRESP_OKAY);
`else
    // Without timeout a held transfer waits indefinitely
    tick(); drive(1, HTRANS_NONSEQ, 32'h8000_0000, 0, 1, 0, 1, HRESP_OKAY);
    for (int i = 0; i < 8; i++) begin
      tick(); drive(0, HTRANS_IDLE, 32'h0, 0, 0, 0, 1, HRESP_OKAY); #2;
      chk("nt_held", held_tran, 1);
      chk("nt_ready", HREADYOUTS, 0);
      chk("nt_resp", HRESPS, HRESP_OKAY);
    end
    tick(); active_ph = 1'b1; #2;
    chk("nt_grant_addr", addr_ph, 32'h8000_0000);
    tick(); drive(0, HTRANS_IDLE, 32'h0, 0, 1, 0, 1, HRESP_OKAY); #2;
    chk("nt_clr_held", held_tran, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
